// File: rtl/noise_tbl_load_ctrl.sv
// ---------------------------------------------------------------------------
// noise_tbl_load_ctrl
//
// Copies the noise probability table from the OCM second read port into the
// noise generator wrapper, one word per cycle. Each word is tagged with its
// table index. After the whole table has gone out, the block waits for the
// wrapper's done_wait acknowledge and then enables noise generation. It
// supports a full reload, a stop/abort, and a sticky timeout error if the
// acknowledge never arrives.
//
// Ports
//   clk           system clock
//   rstn          asynchronous active-low reset
//   start         pulse: begin a load (accepted in IDLE, RUN or ERR)
//   stop          pulse: abort/stop, return to IDLE (wins over start)
//   mem_addr      OCM port-2 address
//   mem_rd        OCM read strobe (mem_addr valid)
//   mem_readdata  OCM port-2 read data, valid RD_LAT cycles after mem_rd
//   tbl_data      table word to the wrapper (mem_data)
//   tbl_location  table index of tbl_data
//   tbl_load      tbl_data/tbl_location valid this cycle
//   done_wait     wrapper acknowledge, level, only looked at in WAIT_ACK
//   noise_en      enable to the noise wrapper
//   busy          high in READ, DRAIN and WAIT_ACK
//   err           sticky acknowledge-timeout flag
//
// States
//   state    | meaning
//   ---------+---------------------------------------------------------
//   IDLE     | nothing in progress, waiting for start
//   READ     | one OCM read issued per cycle, NUM_WORDS in total
//   DRAIN    | reads done, waiting for the last word to reach the wrapper
//   WAIT_ACK | table delivered, waiting for done_wait (bounded by TIMEOUT)
//   RUN      | noise generation enabled
//   ERR      | acknowledge timed out, err held
// ---------------------------------------------------------------------------
module noise_tbl_load_ctrl #(
   parameter int ADDR_W    = 14,
   parameter int DATA_W    = 64,
   parameter int NUM_WORDS = 128,
   parameter int BASE_ADDR = 0,
   parameter int ADDR_STEP = 4,
   parameter int RD_LAT    = 1,
   parameter int TIMEOUT   = 1024
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              start,
   input  logic              stop,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_rd,
   input  logic [DATA_W-1:0] mem_readdata,
   output logic [DATA_W-1:0] tbl_data,
   output logic [7:0]        tbl_location,
   output logic              tbl_load,
   input  logic              done_wait,
   output logic              noise_en,
   output logic              busy,
   output logic              err
);

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_READ     = 3'd1;
   localparam logic [2:0] S_DRAIN    = 3'd2;
   localparam logic [2:0] S_WAIT_ACK = 3'd3;
   localparam logic [2:0] S_RUN      = 3'd4;
   localparam logic [2:0] S_ERR      = 3'd5;

   localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

   localparam logic [ADDR_W-1:0] BASE_A   = ADDR_W'(BASE_ADDR);
   localparam logic [ADDR_W-1:0] STEP_A   = ADDR_W'(ADDR_STEP);
   localparam logic [7:0]        LAST_IDX = 8'(NUM_WORDS - 1);
   localparam logic [TMO_W-1:0]  TMO_LOAD = TMO_W'(TIMEOUT - 1);

   logic [2:0]       state_q;
   logic [2:0]       state_d;
   logic [7:0]       issue_idx_q;
   logic [TMO_W-1:0] tmo_cnt_q;

   // Return path: one valid bit and one table index per cycle of read latency.
   logic [RD_LAT-1:0] rsp_vld_q;
   logic [7:0]        rsp_idx_q [RD_LAT];

   logic enter_read;
   logic enter_wait;
   logic flush;
   logic last_delivered;

   // tbl_location only equals the last index on a live pulse once per load,
   // so this marks the cycle the final word is presented to the wrapper.
   assign last_delivered = tbl_load && (tbl_location == LAST_IDX);

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (start && !stop) state_d = S_READ;
         end
         S_READ: begin
            if (stop)                           state_d = S_IDLE;
            else if (issue_idx_q == LAST_IDX)   state_d = S_DRAIN;
         end
         S_DRAIN: begin
            if (stop)                state_d = S_IDLE;
            else if (last_delivered) state_d = S_WAIT_ACK;
         end
         S_WAIT_ACK: begin
            if (stop)                   state_d = S_IDLE;
            else if (done_wait)         state_d = S_RUN;
            else if (tmo_cnt_q == '0)   state_d = S_ERR;
         end
         S_RUN, S_ERR: begin
            if (stop)       state_d = S_IDLE;
            else if (start) state_d = S_READ;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign enter_read = (state_d == S_READ) && (state_q != S_READ);
   assign enter_wait = (state_d == S_WAIT_ACK) && (state_q != S_WAIT_ACK);
   // Anything heading to IDLE drops in-flight reads and clears the counters.
   assign flush      = (state_d == S_IDLE);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q     <= S_IDLE;
         mem_addr    <= BASE_A;
         mem_rd      <= 1'b0;
         issue_idx_q <= '0;
         tmo_cnt_q   <= '0;
         noise_en    <= 1'b0;
         busy        <= 1'b0;
         err         <= 1'b0;
      end else begin
         state_q  <= state_d;
         mem_rd   <= (state_d == S_READ);
         noise_en <= (state_d == S_RUN);
         busy     <= (state_d == S_READ) || (state_d == S_DRAIN) ||
                     (state_d == S_WAIT_ACK);

         // mem_addr and issue_idx_q always describe the read on the port now.
         if (enter_read) begin
            mem_addr    <= BASE_A;
            issue_idx_q <= '0;
         end else if (state_d == S_READ) begin
            mem_addr    <= mem_addr + STEP_A;
            issue_idx_q <= issue_idx_q + 8'd1;
         end else if (flush) begin
            mem_addr    <= BASE_A;
            issue_idx_q <= '0;
         end

         // Down-counter: the acknowledge is missed when it reaches zero.
         if (enter_wait) begin
            tmo_cnt_q <= TMO_LOAD;
         end else if (state_d == S_WAIT_ACK) begin
            tmo_cnt_q <= tmo_cnt_q - TMO_W'(1);
         end else if (flush) begin
            tmo_cnt_q <= '0;
         end

         // A stop from ERR leaves err set; only a fresh load clears it.
         if ((state_q == S_WAIT_ACK) && (state_d == S_ERR)) begin
            err <= 1'b1;
         end else if (enter_read) begin
            err <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         rsp_vld_q    <= '0;
         for (int j = 0; j < RD_LAT; j++) rsp_idx_q[j] <= '0;
         tbl_load     <= 1'b0;
         tbl_data     <= '0;
         tbl_location <= '0;
      end else if (flush) begin
         rsp_vld_q <= '0;
         tbl_load  <= 1'b0;
      end else begin
         rsp_vld_q[0] <= mem_rd;
         rsp_idx_q[0] <= issue_idx_q;
         for (int j = 1; j < RD_LAT; j++) begin
            rsp_vld_q[j] <= rsp_vld_q[j-1];
            rsp_idx_q[j] <= rsp_idx_q[j-1];
         end
         // The last stage lines up with the cycle mem_readdata is valid.
         tbl_load <= rsp_vld_q[RD_LAT-1];
         if (rsp_vld_q[RD_LAT-1]) begin
            tbl_data     <= mem_readdata;
            tbl_location <= rsp_idx_q[RD_LAT-1];
         end
      end
   end

endmodule

// File: tb/tb_noise_tbl_load_ctrl.sv
// ---------------------------------------------------------------------------
// tb_noise_tbl_load_ctrl
//
// Bench for noise_tbl_load_ctrl. Two instances with different geometry share
// one stimulus thread; cur selects which instance is driven and observed.
// A small OCM model per instance returns a scrambled word per address with the
// instance's read latency. Reads and table loads are logged as transactions
// and compared with the expected address/data/location/cycle sequence.
// ---------------------------------------------------------------------------
module tb_noise_tbl_load_ctrl;

   localparam int AW = 14;
   localparam int DW = 64;

   localparam int N_A = 8,  LAT_A = 1, TMO_A = 16, BASE_A = 0,     STEP_A = 4;
   localparam int N_B = 4,  LAT_B = 3, TMO_B = 5,  BASE_B = 16380, STEP_B = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rstn;
   logic start, stop, done_wait;
   logic cur;

   logic          start_a, stop_a, done_wait_a;
   logic [AW-1:0] mem_addr_a;
   logic          mem_rd_a;
   logic [DW-1:0] mem_readdata_a, tbl_data_a;
   logic [7:0]    tbl_loc_a;
   logic          tbl_load_a, noise_en_a, busy_a, err_a;

   logic          start_b, stop_b, done_wait_b;
   logic [AW-1:0] mem_addr_b;
   logic          mem_rd_b;
   logic [DW-1:0] mem_readdata_b, tbl_data_b;
   logic [7:0]    tbl_loc_b;
   logic          tbl_load_b, noise_en_b, busy_b, err_b;

   assign start_a     = start & ~cur;
   assign stop_a      = stop & ~cur;
   assign done_wait_a = done_wait & ~cur;
   assign start_b     = start & cur;
   assign stop_b      = stop & cur;
   assign done_wait_b = done_wait & cur;

   noise_tbl_load_ctrl #(
      .ADDR_W(AW), .DATA_W(DW), .NUM_WORDS(N_A), .BASE_ADDR(BASE_A),
      .ADDR_STEP(STEP_A), .RD_LAT(LAT_A), .TIMEOUT(TMO_A)
   ) u_dut_a (
      .clk(clk), .rstn(rstn), .start(start_a), .stop(stop_a),
      .mem_addr(mem_addr_a), .mem_rd(mem_rd_a), .mem_readdata(mem_readdata_a),
      .tbl_data(tbl_data_a), .tbl_location(tbl_loc_a), .tbl_load(tbl_load_a),
      .done_wait(done_wait_a), .noise_en(noise_en_a), .busy(busy_a), .err(err_a)
   );

   noise_tbl_load_ctrl #(
      .ADDR_W(AW), .DATA_W(DW), .NUM_WORDS(N_B), .BASE_ADDR(BASE_B),
      .ADDR_STEP(STEP_B), .RD_LAT(LAT_B), .TIMEOUT(TMO_B)
   ) u_dut_b (
      .clk(clk), .rstn(rstn), .start(start_b), .stop(stop_b),
      .mem_addr(mem_addr_b), .mem_rd(mem_rd_b), .mem_readdata(mem_readdata_b),
      .tbl_data(tbl_data_b), .tbl_location(tbl_loc_b), .tbl_load(tbl_load_b),
      .done_wait(done_wait_b), .noise_en(noise_en_b), .busy(busy_b), .err(err_b)
   );

   logic [AW-1:0] o_mem_addr;
   logic          o_mem_rd, o_tbl_load, o_noise_en, o_busy, o_err;
   logic [DW-1:0] o_tbl_data;
   logic [7:0]    o_tbl_loc;

   assign o_mem_addr = cur ? mem_addr_b : mem_addr_a;
   assign o_mem_rd   = cur ? mem_rd_b   : mem_rd_a;
   assign o_tbl_load = cur ? tbl_load_b : tbl_load_a;
   assign o_tbl_data = cur ? tbl_data_b : tbl_data_a;
   assign o_tbl_loc  = cur ? tbl_loc_b  : tbl_loc_a;
   assign o_noise_en = cur ? noise_en_b : noise_en_a;
   assign o_busy     = cur ? busy_b     : busy_a;
   assign o_err      = cur ? err_b      : err_a;

   // OCM contents: word i of a table at stride 4 is A000_..._0000 + i.
   logic [63:0] mem_scr = 64'd0;

   function automatic logic [63:0] ocm_word(input logic [AW-1:0] a);
      return (64'hA000_0000_0000_0000 + 64'(a >> 2)) ^ mem_scr;
   endfunction

   logic [63:0] pipe_a [LAT_A];
   logic [63:0] pipe_b [LAT_B];

   always @(posedge clk) begin
      for (int j = LAT_A - 1; j > 0; j--) pipe_a[j] <= pipe_a[j-1];
      pipe_a[0] <= ocm_word(mem_addr_a);
      for (int j = LAT_B - 1; j > 0; j--) pipe_b[j] <= pipe_b[j-1];
      pipe_b[0] <= ocm_word(mem_addr_b);
   end

   assign mem_readdata_a = pipe_a[LAT_A-1];
   assign mem_readdata_b = pipe_b[LAT_B-1];

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int            rd_cyc  [$];
   logic [AW-1:0] rd_addr [$];
   int            ld_cyc  [$];
   logic [63:0]   ld_data [$];
   logic [7:0]    ld_loc  [$];

   always @(negedge clk) begin
      if (rstn === 1'b1) begin
         if (o_mem_rd === 1'b1) begin
            rd_cyc.push_back(cyc);
            rd_addr.push_back(o_mem_addr);
         end
         if (o_tbl_load === 1'b1) begin
            ld_cyc.push_back(cyc);
            ld_data.push_back(o_tbl_data);
            ld_loc.push_back(o_tbl_loc);
         end
      end
   end

   int total = 0;
   int bad   = 0;

   int nw, lat, tmo, base, stp;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n = 1);
      repeat (n) begin
         @(negedge clk);
         #1;
      end
   endtask

   task automatic sel(input logic d);
      cur  = d;
      nw   = d ? N_B    : N_A;
      lat  = d ? LAT_B  : LAT_A;
      tmo  = d ? TMO_B  : TMO_A;
      base = d ? BASE_B : BASE_A;
      stp  = d ? STEP_B : STEP_A;
      #1;
   endtask

   function automatic logic [AW-1:0] exp_addr(input int i);
      int a;
      a = (base + i * stp) % (1 << AW);
      return a[AW-1:0];
   endfunction

   task automatic clear_log();
      rd_cyc.delete(); rd_addr.delete();
      ld_cyc.delete(); ld_data.delete(); ld_loc.delete();
   endtask

   // Full load from the current state, then acknowledge after ack_delay idle
   // WAIT_ACK cycles. early_ack holds done_wait high through READ/DRAIN.
   task automatic run_load(input int ack_delay, input bit early_ack);
      int t0, jstart, flag_bad;
      clear_log();
      start = 1'b1;
      t0 = cyc;
      step();
      start = 1'b0;
      done_wait = early_ack;
      jstart = $urandom_range(1, nw + lat);
      flag_bad = 0;
      for (int c = 1; c <= nw + lat + 1; c++) begin
         if (o_busy !== 1'b1 || o_noise_en !== 1'b0 || o_err !== 1'b0) flag_bad++;
         start = (c == jstart);
         step();
      end
      start = 1'b0;
      done_wait = 1'b0;
      chk("load_flags", 64'(flag_bad), 64'd0);
      chk("rd_count", 64'(rd_cyc.size()), 64'(nw));
      chk("ld_count", 64'(ld_cyc.size()), 64'(nw));
      for (int i = 0; i < nw && i < rd_cyc.size(); i++) begin
         chk("rd_cycle", 64'(rd_cyc[i] - t0), 64'(1 + i));
         chk("rd_addr", 64'(rd_addr[i]), 64'(exp_addr(i)));
      end
      for (int i = 0; i < nw && i < ld_cyc.size(); i++) begin
         chk("ld_cycle", 64'(ld_cyc[i] - t0), 64'(lat + 2 + i));
         chk("ld_loc", 64'(ld_loc[i]), 64'(i));
         chk("ld_data", ld_data[i], ocm_word(exp_addr(i)));
      end
      chk("wait_busy", 64'(o_busy), 64'd1);
      chk("wait_en", 64'(o_noise_en), 64'd0);
      step(ack_delay);
      chk("pre_ack_busy", 64'(o_busy), 64'd1);
      done_wait = 1'b1;
      step();
      done_wait = 1'b0;
      chk("run_en", 64'(o_noise_en), 64'd1);
      chk("run_busy", 64'(o_busy), 64'd0);
      chk("run_err", 64'(o_err), 64'd0);
   endtask

   task automatic stop_test();
      int t0, exp_ld;
      clear_log();
      start = 1'b1;
      t0 = cyc;
      step();
      start = 1'b0;
      step(2);
      stop = 1'b1;
      step();
      stop = 1'b0;
      chk("stop_rd", 64'(o_mem_rd), 64'd0);
      chk("stop_busy", 64'(o_busy), 64'd0);
      chk("stop_en", 64'(o_noise_en), 64'd0);
      step(lat + 3);
      exp_ld = (lat < 2) ? 2 - lat : 0;
      chk("stop_rd_count", 64'(rd_cyc.size()), 64'd3);
      chk("stop_ld_count", 64'(ld_cyc.size()), 64'(exp_ld));
      for (int i = 0; i < ld_cyc.size(); i++)
         chk("stop_ld_cycle", 64'(ld_cyc[i] - t0 <= 3), 64'd1);
      start = 1'b1;
      stop  = 1'b1;
      step();
      start = 1'b0;
      stop  = 1'b0;
      chk("both_busy", 64'(o_busy), 64'd0);
      chk("both_rd", 64'(o_mem_rd), 64'd0);
      step(3);
      chk("both_rd_count", 64'(rd_cyc.size()), 64'd3);
   endtask

   // Load with no acknowledge; optional stop from ERR afterwards.
   task automatic tmo_test(input bit via_stop);
      start = 1'b1;
      step();
      start = 1'b0;
      done_wait = 1'b0;
      step(nw + lat + 1);
      step(tmo - 1);
      chk("tmo_last_busy", 64'(o_busy), 64'd1);
      chk("tmo_last_err", 64'(o_err), 64'd0);
      step();
      chk("tmo_err", 64'(o_err), 64'd1);
      chk("tmo_busy", 64'(o_busy), 64'd0);
      chk("tmo_en", 64'(o_noise_en), 64'd0);
      step(2);
      chk("tmo_err_hold", 64'(o_err), 64'd1);
      if (via_stop) begin
         stop = 1'b1;
         step();
         stop = 1'b0;
         chk("stop_err_hold", 64'(o_err), 64'd1);
         chk("stop_err_busy", 64'(o_busy), 64'd0);
      end
   endtask

   task automatic reset_test();
      start = 1'b1;
      step();
      start = 1'b0;
      step(3);
      rstn = 1'b0;
      #1;
      chk("rst_rd", 64'(o_mem_rd), 64'd0);
      chk("rst_addr", 64'(o_mem_addr), 64'(base));
      chk("rst_load", 64'(o_tbl_load), 64'd0);
      chk("rst_data", o_tbl_data, 64'd0);
      chk("rst_loc", 64'(o_tbl_loc), 64'd0);
      chk("rst_busy", 64'(o_busy), 64'd0);
      chk("rst_en", 64'(o_noise_en), 64'd0);
      chk("rst_err", 64'(o_err), 64'd0);
      step(2);
      rstn = 1'b1;
      step();
      chk("rst_idle_load", 64'(o_tbl_load), 64'd0);
   endtask

   initial begin
      rstn = 1'b0;
      start = 1'b0;
      stop = 1'b0;
      done_wait = 1'b0;
      sel(1'b0);
      step(3);
      chk("init_addr_a", 64'(o_mem_addr), 64'(BASE_A));
      chk("init_rd_a", 64'(o_mem_rd), 64'd0);
      chk("init_load_a", 64'(o_tbl_load), 64'd0);
      chk("init_busy_a", 64'(o_busy), 64'd0);
      chk("init_en_a", 64'(o_noise_en), 64'd0);
      chk("init_err_a", 64'(o_err), 64'd0);
      sel(1'b1);
      chk("init_addr_b", 64'(o_mem_addr), 64'(BASE_B));
      chk("init_data_b", o_tbl_data, 64'd0);
      sel(1'b0);
      rstn = 1'b1;
      step(2);

      for (int d = 0; d < 2; d++) begin
         sel(d[0]);
         mem_scr = 64'd0;
         run_load(1, 1'b0);
         mem_scr = {$urandom, $urandom};
         run_load($urandom_range(0, tmo - 1), 1'b1);
         stop_test();
         mem_scr = {$urandom, $urandom};
         tmo_test(1'b0);
         run_load($urandom_range(0, tmo - 1), 1'b0);
         tmo_test(1'b1);
         run_load(tmo - 1, 1'b1);
         reset_test();
         mem_scr = {$urandom, $urandom};
         run_load(0, 1'b0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
